// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, tx state encoding, data-width limits.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam logic [3:0] DBITS_MIN = 4'd5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    function automatic logic [3:0] clamp_dbits(input logic [3:0] req, input logic [3:0] max_bits);
        if (req < DBITS_MIN)
            return DBITS_MIN;
        else if (req > max_bits)
            return max_bits;
        else
            return req;
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Request/config/status bundle between a frame producer and uart_tx_cfg.
interface uart_tx_cfg_if #(
    parameter int DBIT_MAX = 8
);
    logic                tx_start;
    logic [DBIT_MAX-1:0] din;
    logic [3:0]          cfg_dbits;
    logic [1:0]          cfg_parity;
    logic                cfg_stop2;
    logic                tx_ready;
    logic                tx_done_tick;

    modport master (
        output tx_start, din, cfg_dbits, cfg_parity, cfg_stop2,
        input  tx_ready, tx_done_tick
    );

    modport slave (
        input  tx_start, din, cfg_dbits, cfg_parity, cfg_stop2,
        output tx_ready, tx_done_tick
    );
endinterface

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter (5..DBIT_MAX data bits, 1/2 stop bits).
// Parity support is built only when UART_TX_PARITY_EN is defined.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DBIT_MAX   = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_tick,
    uart_tx_cfg_if.slave  bus,
    output logic          tx
);

    localparam int              CW        = $clog2(2 * OVERSAMPLE);
    localparam logic [CW-1:0]   BIT_LAST  = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0]   STOP2_LAST = CW'(2 * OVERSAMPLE - 1);
    localparam logic [3:0]      DMAX      = 4'(DBIT_MAX);

    tx_state_t           state_reg, state_next;
    logic [CW-1:0]       s_reg, s_next;
    logic [3:0]          n_reg, n_next;
    logic [3:0]          nb_reg, nb_next;
    logic [DBIT_MAX-1:0] b_reg, b_next;
    logic                stop2_reg, stop2_next;
    logic                tx_reg, tx_next;
`ifdef UART_TX_PARITY_EN
    logic                par_reg, par_next;
    logic [1:0]          pm_reg, pm_next;
`else
    logic                unused_cfg_parity;
    assign unused_cfg_parity = ^bus.cfg_parity;
`endif

    logic bit_end, stop_end;
    assign bit_end  = s_tick && (s_reg == BIT_LAST);
    assign stop_end = s_tick && (s_reg == (stop2_reg ? STOP2_LAST : BIT_LAST));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            s_reg     <= '0;
            n_reg     <= '0;
            nb_reg    <= '0;
            b_reg     <= '0;
            stop2_reg <= 1'b0;
            tx_reg    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_reg   <= 1'b0;
            pm_reg    <= PAR_NONE;
`endif
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            n_reg     <= n_next;
            nb_reg    <= nb_next;
            b_reg     <= b_next;
            stop2_reg <= stop2_next;
            tx_reg    <= tx_next;
`ifdef UART_TX_PARITY_EN
            par_reg   <= par_next;
            pm_reg    <= pm_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        n_next     = n_reg;
        nb_next    = nb_reg;
        b_next     = b_reg;
        stop2_next = stop2_reg;
`ifdef UART_TX_PARITY_EN
        par_next   = par_reg;
        pm_next    = pm_reg;
`endif
        case (state_reg)
            IDLE: begin
                // Everything the frame needs is captured here so later input changes cannot leak in.
                if (bus.tx_start) begin
                    state_next = START;
                    s_next     = '0;
                    n_next     = '0;
                    b_next     = bus.din;
                    nb_next    = clamp_dbits(bus.cfg_dbits, DMAX);
                    stop2_next = bus.cfg_stop2;
`ifdef UART_TX_PARITY_EN
                    par_next   = 1'b0;
                    pm_next    = bus.cfg_parity;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    s_next     = '0;
                    n_next     = '0;
                end else if (s_tick) begin
                    s_next = CW'(s_reg + 1'b1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    s_next = '0;
                    b_next = b_reg >> 1;
`ifdef UART_TX_PARITY_EN
                    par_next = par_reg ^ b_reg[0];
`endif
                    if (n_reg == 4'(nb_reg - 4'd1)) begin
`ifdef UART_TX_PARITY_EN
                        state_next = (pm_reg == PAR_EVEN || pm_reg == PAR_ODD) ? PARITY : STOP;
`else
                        state_next = STOP;
`endif
                    end else begin
                        n_next = n_reg + 4'd1;
                    end
                end else if (s_tick) begin
                    s_next = CW'(s_reg + 1'b1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                    s_next     = '0;
                end else if (s_tick) begin
                    s_next = CW'(s_reg + 1'b1);
                end
            end
`endif
            STOP: begin
                // Counter spans both stop bits when two are configured.
                if (stop_end) begin
                    state_next = IDLE;
                    s_next     = '0;
                end else if (s_tick) begin
                    s_next = CW'(s_reg + 1'b1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.tx_ready     = (state_reg == IDLE);
        bus.tx_done_tick = (state_reg == STOP) && stop_end;
        // tx is registered from the next-state view so the start bit appears on the accept edge.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = b_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_next = par_next ^ (pm_reg == PAR_ODD);
`endif
            default: tx_next = 1'b1;
        endcase
    end

    assign tx = tx_reg;

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised, runtime-configurable UART serial transmitter. It is the successor to the fixed 8N1 transmitter.
- Data width is selectable from 5 to DBIT_MAX bits per frame.
- Optional even or odd parity.
- One or two stop bits.
- Oversampling factor is set by a parameter.
- Driven by the shared external baud-tick generator (s_tick); feeds the board TX pin.

Parameters:
DBIT_MAX, 8, maximum data bits per frame and width of din (legal 5..9).
OVERSAMPLE, 16, s_tick pulses per bit period (legal 4..32).

Ports:
clk  input  1  system clock; single clock domain.
reset  input  1  synchronous, active-high reset.
s_tick  input  1  baud oversample strobe, one clk wide.
tx_start  input  1  request to send din; accepted only while tx_ready=1.
din  input  DBIT_MAX  data word, sent LSB first.
cfg_dbits  input  4  data bits per frame.
cfg_parity  input  2  parity mode: 00 none, 01 even, 10 odd, 11 none.
cfg_stop2  input  1  0 = one stop bit, 1 = two stop bits.
tx_ready  output  1  high in IDLE.
tx_done_tick  output  1  one-clk pulse at end of the last stop bit.
tx  output  1  serial line, registered, idle high.

Behaviour:
- Reset (sampled on the clk edge):
  - State goes to IDLE; tx=1, tx_ready=1, tx_done_tick=0.
  - All counters and shift registers clear.
  - Reset during a frame aborts it immediately: no done tick, line high next edge.
- States and transitions: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- Acceptance:
  - tx_start is accepted when high on an edge with state=IDLE.
  - On acceptance, din, cfg_dbits, cfg_parity and cfg_stop2 are latched.
  - tx falls to 0 on that same edge (one-clk latency).
  - Config or din changes after acceptance do not affect the frame in flight.
  - tx_start while not IDLE is ignored and is not queued.
- Bit timing:
  - Tick counter width is clog2(2*OVERSAMPLE).
  - Each bit lasts exactly OVERSAMPLE s_ticks.
  - The bit advances on the edge where s_tick=1 and count=OVERSAMPLE-1; the counter then returns to 0.
  - Clocks without s_tick hold all state.
- Data bit count:
  - cfg_dbits below 5 is clamped to 5; above DBIT_MAX is clamped to DBIT_MAX.
  - Bits of din above the latched count are ignored.
- DATA: tx = shift_reg[0]; shift right once per bit; leave after the clamped count of bits.
- PARITY: entered only if the latched mode is 01 or 10.
  - Even: tx = XOR of the transmitted data bits.
  - Odd: tx = inverse of that XOR.
  - Parity accumulates serially during DATA.
- STOP: tx=1 for OVERSAMPLE ticks, or 2*OVERSAMPLE ticks if cfg_stop2 was latched.
  - tx_done_tick is asserted combinationally on the final stop-bit tick edge.
  - The next state is IDLE, so tx_ready=1 from the following clk.
  - The earliest back-to-back start is the clk after tx_done_tick.
- Frame length in s_ticks = (1 + N + P + S) * OVERSAMPLE, where N = data bits, P = parity bit (0/1), S = stop bits (1/2).

Optional Feature:
UART_TX_PARITY_EN
- Defined: PARITY state and parity accumulator are present; cfg_parity behaves as above.
- Undefined: no PARITY state or accumulator is built; cfg_parity remains a port but is ignored; all frames are sent without parity.

Decomposition:
- Shared package uart_pkg holds:
  - parity-mode constants PAR_NONE, PAR_EVEN, PAR_ODD;
  - tx state encoding IDLE, START, DATA, PARITY, STOP;
  - the minimum data-bits constant (5).
- No sub-module: the tick counter, bit counter, shifter and parity accumulator are small and tightly coupled, so the block is a single FSM module.

Test Plan:
- OVERSAMPLE=16, 8N1, din=0x55, tick every clk -> tx sequence 0,1,0,1,0,1,0,1,0,1, each 16 ticks; tx_done_tick after 160 ticks; tx_ready high the next clk.
- 7E2, din=0x41 -> start, 1000001 LSB first, parity 0, two stop bits (32 ticks); done at 176 ticks.
- 5O1, din=0xFF -> data 11111 (upper bits dropped), parity 0, one stop bit; done at 128 ticks. Repeat with cfg_dbits=2 -> behaves as 5 bits.
- tx_start pulsed and din/cfg changed mid-DATA -> frame unchanged; no second frame; tx_ready stays 0.
- reset asserted during the 4th data bit -> tx=1 and tx_ready=1 on the next edge; no tx_done_tick. A new 8N1 frame after reset is correct.
- s_tick every 3rd clk, back-to-back frames 0xA5 then 0x3C -> second start accepted the clk after the first tx_done_tick; bit widths are exactly 16 ticks. Build with UART_TX_PARITY_EN undefined and cfg_parity=01 -> no parity bit sent.
